// File: rtl/cpu_types_pkg.sv
// Shared CPU datapath types: the machine word and the instruction-cache frame.
package cpu_types_pkg;

    localparam int CPU_WORD_W = 32;

    typedef logic [CPU_WORD_W-1:0] word_t;

    // One cache frame. The tag is stored right-aligned (address >> (IDX_W+2)),
    // so the upper bits of the field are zero for any realistic set count.
    typedef struct packed {
        logic  valid;
        word_t tag;
        word_t data;
    } icache_frame_t;

endpackage

// File: rtl/icache_dm_array.sv
// Frame storage for icache_dm: SETS frames, one write port, combinational read.
// Valid bits are cleared synchronously on rst; tag/data are left uninitialised.
// With ICACHE_PREFETCH_EN defined, a second read port looks up the next line.
module icache_dm_array
    import cpu_types_pkg::*;
#(
    parameter int SETS = 16,
    localparam int IDX_W = $clog2(SETS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             we,
    input  logic [IDX_W-1:0] widx,
    input  word_t            wtag,
    input  word_t            wdata,
    input  logic [IDX_W-1:0] ridx,
    output icache_frame_t    rframe
`ifdef ICACHE_PREFETCH_EN
    ,
    input  logic [IDX_W-1:0] pidx,
    output icache_frame_t    pframe
`endif
);

    logic [SETS-1:0] valid_bits;
    word_t           tag_mem  [SETS];
    word_t           data_mem [SETS];

    // Valid bits: cleared by reset, set by a fill. A fill racing reset is dropped.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_bits <= '0;
        end else if (we) begin
            valid_bits[widx] <= 1'b1;
        end
    end

    // Tag/data storage: no reset, written only by a fill outside reset.
    always_ff @(posedge clk) begin
        if (we && !rst) begin
            tag_mem[widx]  <= wtag;
            data_mem[widx] <= wdata;
        end
    end

    assign rframe.valid = valid_bits[ridx];
    assign rframe.tag   = tag_mem[ridx];
    assign rframe.data  = data_mem[ridx];

`ifdef ICACHE_PREFETCH_EN
    assign pframe.valid = valid_bits[pidx];
    assign pframe.tag   = tag_mem[pidx];
    assign pframe.data  = data_mem[pidx];
`endif

endmodule

// File: rtl/icache_dm.sv
// Direct-mapped, one-word-per-frame instruction cache. Hits are served in the
// same cycle; a miss requests the word from the memory controller over
// iREN/iaddr, holds until iwait falls, fills the frame and returns to IDLE.
// Optional macro ICACHE_PREFETCH_EN adds a single next-line prefetch after
// every demand fill (no chaining, no wrap past 0xFFFFFFFC).
module icache_dm
    import cpu_types_pkg::*;
#(
    parameter int SETS   = 16,
    parameter int WORD_W = 32
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              imemREN,
    input  logic [WORD_W-1:0] imemaddr,
    output logic              ihit,
    output logic [WORD_W-1:0] imemload,
    output logic              iREN,
    output logic [WORD_W-1:0] iaddr,
    input  logic              iwait,
    input  logic [WORD_W-1:0] iload
);

    localparam int IDX_W = $clog2(SETS);

`ifdef ICACHE_PREFETCH_EN
    typedef enum logic [1:0] {IDLE, FETCH, PREFETCH} state_t;
`else
    typedef enum logic [0:0] {IDLE, FETCH} state_t;
`endif

    function automatic logic [IDX_W-1:0] idx_of(input word_t a);
        return a[IDX_W+1:2];
    endfunction

    function automatic word_t tag_of(input word_t a);
        return a >> (IDX_W + 2);
    endfunction

    state_t        state;
    word_t         miss_addr;
    icache_frame_t rd_frame;
    logic          tag_match;
    logic          fill;

    assign tag_match = rd_frame.valid && (rd_frame.tag == tag_of(imemaddr));
    assign fill      = (state != IDLE) && !iwait;
    assign iaddr     = miss_addr;

    // imemload is only meaningful with ihit; an invalid frame reads as zero so
    // the output is clean straight out of reset despite the unreset data array.
    assign imemload  = rd_frame.valid ? rd_frame.data : '0;

`ifdef ICACHE_PREFETCH_EN
    word_t         next_addr;
    icache_frame_t pf_frame;
    logic          pf_skip;
    logic          unused_pf_data;

    assign next_addr      = miss_addr + 32'd4;
    assign pf_skip        = (miss_addr == 32'hFFFF_FFFC) ||
                            (pf_frame.valid && (pf_frame.tag == tag_of(next_addr)));
    assign unused_pf_data = ^pf_frame.data;
`endif

    icache_dm_array #(.SETS(SETS)) u_array (
        .clk    (CLK),
        .rst    (RST),
        .we     (fill),
        .widx   (idx_of(miss_addr)),
        .wtag   (tag_of(miss_addr)),
        .wdata  (iload),
        .ridx   (idx_of(imemaddr)),
        .rframe (rd_frame)
`ifdef ICACHE_PREFETCH_EN
        ,
        .pidx   (idx_of(next_addr)),
        .pframe (pf_frame)
`endif
    );

    // Hit decode: full service in IDLE; during a prefetch only frames other
    // than the one being filled may hit; never during a demand fetch.
    always_comb begin
        ihit = 1'b0;
        case (state)
            IDLE:     ihit = imemREN && tag_match;
`ifdef ICACHE_PREFETCH_EN
            PREFETCH: ihit = imemREN && tag_match &&
                             (idx_of(imemaddr) != idx_of(miss_addr));
`endif
            default:  ihit = 1'b0;
        endcase
    end

    // Miss/fill sequencer with registered iREN and request address.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state     <= IDLE;
            miss_addr <= '0;
            iREN      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (imemREN && !tag_match) begin
                        miss_addr <= {imemaddr[WORD_W-1:2], 2'b00};
                        iREN      <= 1'b1;
                        state     <= FETCH;
                    end
                end
                FETCH: begin
                    if (!iwait) begin
`ifdef ICACHE_PREFETCH_EN
                        if (pf_skip) begin
                            iREN  <= 1'b0;
                            state <= IDLE;
                        end else begin
                            miss_addr <= next_addr;
                            state     <= PREFETCH;
                        end
`else
                        iREN  <= 1'b0;
                        state <= IDLE;
`endif
                    end
                end
`ifdef ICACHE_PREFETCH_EN
                PREFETCH: begin
                    if (!iwait) begin
                        iREN  <= 1'b0;
                        state <= IDLE;
                    end
                end
`endif
                default: begin
                    iREN  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_icache_dm.sv
// Self-checking bench for icache_dm: directed scenarios with literal
// expectations, then randomized traffic against a behavioural cache model.
// Compile with +define+ICACHE_PREFETCH_EN to exercise the prefetch build.
module tb_icache_dm;

    localparam int SETS = 16;

`ifdef ICACHE_PREFETCH_EN
    localparam bit PF = 1'b1;
`else
    localparam bit PF = 1'b0;
`endif

    logic        CLK = 1'b0;
    logic        RST, imemREN, iwait, ihit, iREN;
    logic [31:0] imemaddr, imemload, iaddr, iload;

    int checks = 0;
    int errors = 0;

    always #5 CLK = ~CLK;

    icache_dm #(.SETS(SETS), .WORD_W(32)) dut (
        .CLK      (CLK),
        .RST      (RST),
        .imemREN  (imemREN),
        .imemaddr (imemaddr),
        .ihit     (ihit),
        .imemload (imemload),
        .iREN     (iREN),
        .iaddr    (iaddr),
        .iwait    (iwait),
        .iload    (iload)
    );

    // Behavioural model: which word address each set holds, and the one
    // outstanding memory request (0 none, 1 demand, 2 prefetch).
    bit          mv    [SETS];
    logic [29:0] mword [SETS];
    logic [31:0] mdata [SETS];
    int          mbusy = 0;
    logic [31:0] mpend = 32'h0;

    function automatic int midx(input logic [31:0] a);
        return int'((a >> 2) % SETS);
    endfunction

    function automatic bit mcached(input logic [31:0] a);
        return mv[midx(a)] && (mword[midx(a)] == a[31:2]);
    endfunction

    function automatic logic [31:0] memfn(input logic [31:0] a);
        return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
    endfunction

    function automatic bit exp_hit();
        if (!imemREN || !mcached(imemaddr)) return 1'b0;
        if (mbusy == 0) return 1'b1;
        if (mbusy == 2 && midx(imemaddr) != midx(mpend)) return 1'b1;
        return 1'b0;
    endfunction

    task automatic chk_bit(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%b required=%b", name, act, exp);
        end
    endtask

    task automatic chk_word(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        checks++;
        errors++;
        $display("FAIL %s actual=no_completion required=completion", name);
    endtask

    task automatic compare();
        bit h;
        h = exp_hit();
        chk_bit("ihit", ihit, h);
        if (h) chk_word("imemload", imemload, mdata[midx(imemaddr)]);
        chk_bit("iREN", iREN, mbusy != 0);
        if (mbusy != 0) chk_word("iaddr", iaddr, mpend);
    endtask

    task automatic model_step();
        bit          h;
        bit          pfgo;
        logic [31:0] nxt;
        h = exp_hit();
        if (RST) begin
            foreach (mv[i]) mv[i] = 1'b0;
            mbusy = 0;
            mpend = 32'h0;
        end else if (mbusy == 0) begin
            if (imemREN && !h) begin
                mbusy = 1;
                mpend = {imemaddr[31:2], 2'b00};
            end
        end else if (!iwait) begin
            nxt  = mpend + 32'd4;
            pfgo = PF && (mbusy == 1) && (mpend != 32'hFFFF_FFFC) && !mcached(nxt);
            mv[midx(mpend)]    = 1'b1;
            mword[midx(mpend)] = mpend[31:2];
            mdata[midx(mpend)] = iload;
            if (pfgo) begin
                mbusy = 2;
                mpend = nxt;
            end else begin
                mbusy = 0;
            end
        end
    endtask

    task automatic cycle(input bit rst, input bit req, input logic [31:0] addr,
                         input bit iw, input logic [31:0] ld);
        @(negedge CLK);
        RST      = rst;
        imemREN  = req;
        imemaddr = addr;
        iwait    = iw;
        iload    = ld;
        #1;
        compare();
    endtask

    task automatic tick();
        @(posedge CLK);
        model_step();
    endtask

    // Requests addr until the miss (and any prefetch) has been fully served.
    task automatic serve(input logic [31:0] addr, input int lat);
        int cnt;
        bit started;
        bit iw;
        cnt     = lat;
        started = 1'b0;
        for (int n = 0; n < 60; n++) begin
            iw = 1'b1;
            if (mbusy != 0) begin
                started = 1'b1;
                if (cnt == 0) begin
                    iw  = 1'b0;
                    cnt = lat;
                end else begin
                    cnt--;
                end
            end
            cycle(1'b0, 1'b1, addr, iw, memfn(mpend));
            tick();
            if (started && mbusy == 0) return;
        end
        timeout("serve");
    endtask

    // Completes whatever request is outstanding with immediate responses.
    task automatic drain();
        for (int n = 0; n < 10; n++) begin
            if (mbusy == 0) return;
            cycle(1'b0, 1'b0, 32'h0, 1'b0, memfn(mpend));
            tick();
        end
        timeout("drain");
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int          cnt;
        logic [31:0] a;
        logic [31:0] prev;
        bit          iw;

        // Power-on reset, no comparison while outputs are still undefined.
        @(negedge CLK);
        RST = 1'b1; imemREN = 1'b0; imemaddr = 32'h0; iwait = 1'b1; iload = 32'h0;
        tick();

        // Reset state.
        cycle(1'b0, 1'b0, 32'h0, 1'b1, 32'h0);
        chk_bit("rst_ihit", ihit, 1'b0);
        chk_bit("rst_iREN", iREN, 1'b0);
        chk_word("rst_iaddr", iaddr, 32'h0);
        chk_word("rst_imemload", imemload, 32'h0);
        tick();

        // Cold miss on 0x40 with three wait cycles.
        cycle(1'b0, 1'b1, 32'h40, 1'b1, 32'h0);
        chk_bit("t1_miss_ihit", ihit, 1'b0);
        tick();
        for (int i = 0; i < 3; i++) begin
            cycle(1'b0, 1'b1, 32'h40, 1'b1, 32'h0);
            chk_bit("t1_iREN", iREN, 1'b1);
            chk_word("t1_iaddr", iaddr, 32'h40);
            tick();
        end
        cycle(1'b0, 1'b1, 32'h40, 1'b0, 32'hDEAD_BEEF);
        chk_bit("t1_done_ihit", ihit, 1'b0);
        tick();
        cycle(1'b0, 1'b1, 32'h40, 1'b1, 32'h0);
        chk_bit("t1_rehit", ihit, 1'b1);
        chk_word("t1_data", imemload, 32'hDEAD_BEEF);
`ifdef ICACHE_PREFETCH_EN
        chk_bit("t1_pf_iREN", iREN, 1'b1);
        chk_word("t1_pf_iaddr", iaddr, 32'h44);
`else
        chk_bit("t1_iREN_low", iREN, 1'b0);
`endif
        tick();
        drain();

        // Conflict: 0x80 evicts 0x40, then 0x40 misses again.
        serve(32'h80, 2);
        cycle(1'b0, 1'b1, 32'h80, 1'b1, 32'h0);
        chk_bit("t2_hit80", ihit, 1'b1);
        chk_word("t2_data80", imemload, memfn(32'h80));
        tick();
        cycle(1'b0, 1'b1, 32'h40, 1'b1, 32'h0);
        chk_bit("t2_miss40", ihit, 1'b0);
        tick();
        cycle(1'b0, 1'b1, 32'h40, 1'b1, 32'h0);
        chk_word("t2_iaddr40", iaddr, 32'h40);
        tick();
        serve(32'h40, 1);

        // Address change mid-miss: request stays on 0x10.
        cycle(1'b0, 1'b1, 32'h10, 1'b1, 32'h0);
        tick();
        for (int i = 0; i < 3; i++) begin
            cycle(1'b0, 1'b1, 32'h20, 1'b1, 32'h0);
            chk_word("t3_iaddr", iaddr, 32'h10);
            tick();
        end
        cycle(1'b0, 1'b1, 32'h20, 1'b0, memfn(32'h10));
        tick();
        drain();
        cycle(1'b0, 1'b1, 32'h10, 1'b1, 32'h0);
        chk_bit("t3_hit10", ihit, 1'b1);
        chk_word("t3_data10", imemload, memfn(32'h10));
        tick();
        cycle(1'b0, 1'b1, 32'h20, 1'b1, 32'h0);
        chk_bit("t3_miss20", ihit, 1'b0);
        tick();

        // Reset during the 0x20 fetch abandons it; nothing stale afterwards.
        cycle(1'b1, 1'b1, 32'h20, 1'b1, 32'h0);
        chk_bit("t4_iREN_before", iREN, 1'b1);
        tick();
        cycle(1'b0, 1'b0, 32'h20, 1'b1, 32'h0);
        chk_bit("t4_iREN_after", iREN, 1'b0);
        tick();
        cycle(1'b0, 1'b1, 32'h20, 1'b1, 32'h0);
        chk_bit("t4_no_stale", ihit, 1'b0);
        tick();
        serve(32'h20, 2);

        // Misaligned request hits the aligned word.
        serve(32'h44, 2);
        cycle(1'b0, 1'b1, 32'h47, 1'b1, 32'h0);
        chk_bit("t5_hit47", ihit, 1'b1);
        chk_word("t5_data47", imemload, memfn(32'h44));
        tick();

        // Miss on 0x100: prefetch of 0x104 and hit on 0x100 while it runs.
        cycle(1'b0, 1'b1, 32'h100, 1'b1, 32'h0);
        tick();
        cycle(1'b0, 1'b1, 32'h100, 1'b0, memfn(32'h100));
        tick();
        cycle(1'b0, 1'b1, 32'h100, 1'b1, 32'h0);
        chk_bit("t6_hit100", ihit, 1'b1);
`ifdef ICACHE_PREFETCH_EN
        chk_bit("t6_pf_iREN", iREN, 1'b1);
        chk_word("t6_pf_iaddr", iaddr, 32'h104);
        tick();
        cycle(1'b0, 1'b0, 32'h0, 1'b0, memfn(32'h104));
        tick();
        cycle(1'b0, 1'b1, 32'h104, 1'b1, 32'h0);
        chk_bit("t6_hit104", ihit, 1'b1);
        chk_word("t6_data104", imemload, memfn(32'h104));
`endif
        tick();
        drain();

        // Top-of-memory miss never prefetches.
        cycle(1'b0, 1'b1, 32'hFFFF_FFFC, 1'b1, 32'h0);
        tick();
        cycle(1'b0, 1'b1, 32'hFFFF_FFFC, 1'b0, memfn(32'hFFFF_FFFC));
        tick();
        cycle(1'b0, 1'b1, 32'hFFFF_FFFC, 1'b1, 32'h0);
        chk_bit("t7_no_pf", iREN, 1'b0);
        chk_bit("t7_hit", ihit, 1'b1);
        tick();

        // Randomized traffic against the model.
        cnt  = 0;
        prev = 32'h0;
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 2) != 0) a = prev;
            else if ($urandom_range(0, 31) == 0) a = 32'hFFFF_FFFC - 32'($urandom_range(0, 1) * 4);
            else a = 32'($urandom_range(0, 1023));
            prev = a;
            if (mbusy != 0) begin
                if (cnt == 0) begin
                    iw  = 1'b0;
                    cnt = $urandom_range(0, 3);
                end else begin
                    iw = 1'b1;
                    cnt--;
                end
            end else begin
                iw = 1'($urandom_range(0, 1));
            end
            cycle($urandom_range(0, 199) == 0, $urandom_range(0, 3) != 0, a, iw,
                  (mbusy != 0) ? memfn(mpend) : $urandom);
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/icache_dm.md
Name: icache_dm

Overview:
- Direct-mapped, one-word-per-frame instruction cache between the datapath fetch stage and the memory controller's instruction port.
- Serves hits in the same cycle.
- On a miss it raises iREN/iaddr toward the memory controller, which arbitrates instruction fetches against coherence/data traffic. It holds the request until iwait falls, then fills the frame.
- One instance per CPU.

Parameters:
- SETS, 16, number of frames; must be a power of 2; index width IDX_W = log2(SETS).
- WORD_W, 32, data and address width (matches word_t).

Ports:
- CLK  in  1  clock, rising edge.
- RST  in  1  reset, synchronous, active-high.
- imemREN  in  1  fetch request from datapath.
- imemaddr  in  32  fetch byte address; bits [1:0] ignored.
- ihit  out  1  requested word valid this cycle.
- imemload  out  32  instruction word, valid when ihit=1.
- iREN  out  1  read request to memory controller.
- iaddr  out  32  word-aligned request address to memory controller.
- iwait  in  1  0 = iload valid this cycle / request done.
- iload  in  32  word returned by memory controller.

Behaviour:
- Address split: tag = addr[31:IDX_W+2]; idx = addr[IDX_W+1:2].
- Storage per frame: valid bit, tag, data word.
- Reset, at the edge with RST=1:
  - all valid bits = 0; state = IDLE; miss_addr = 0.
  - Outputs in the following cycle: ihit=0, iREN=0, iaddr=0, imemload=0.
  - Tag/data arrays need not be reset.
  - RST during FETCH or PREFETCH abandons the fill; no frame is written.
- FSM states: IDLE, FETCH, PREFETCH (PREFETCH exists only with the optional feature).
- IDLE:
  - hit = imemREN & valid[idx] & tag match; ihit=hit, imemload=data[idx], combinational.
  - On imemREN & !hit: latch miss_addr = {imemaddr[31:2], 2'b00}; go to FETCH.
  - iREN=0 in IDLE.
- FETCH:
  - iREN=1, iaddr=miss_addr.
  - While iwait=1, hold state.
  - On iwait=0: write the frame at miss_addr idx (data=iload, tag, valid=1); go to IDLE (or PREFETCH).
  - ihit=0 throughout FETCH, including the completion cycle.
  - The requester re-hits in the next cycle, so miss penalty = memory latency + 1 cycle.
- A fill is never aborted by imemREN falling or imemaddr changing; the latched miss_addr is used.
- Writing a frame that already holds a valid line overwrites it (no writeback; instruction lines are clean).
- iwait=0 while iREN=0 is ignored.
- imemload is a don't-care when ihit=0; drive the data[idx] value.

Optional Feature:
- Macro ICACHE_PREFETCH_EN.
- When defined, after a FETCH completes for address A, next-line prefetch of P = A+4:
  - Skip the prefetch (go to IDLE) if frame[P] is already valid with a matching tag.
  - Skip the prefetch if A = 0xFFFFFFFC (no wrap to 0).
  - Otherwise go to PREFETCH: iREN=1, iaddr=P; on iwait=0, fill frame[P] and go to IDLE.
  - During PREFETCH, hits are served for idx != idx(P). A miss, or an access to idx(P), gets ihit=0 and is handled after return to IDLE.
  - A prefetch is never chained; PREFETCH always returns to IDLE.
- When undefined: no PREFETCH state; FETCH always returns to IDLE; no prefetch logic is synthesized.

Decomposition:
- Shared package (cpu_types_pkg): word_t, plus a new icache_frame_t struct {valid, tag, data}.
- The icache state enum stays local to the module.
- One natural sub-module: icache_dm_array, the frame storage (SETS entries, one write port, combinational read, sync valid clear on RST).

Test Plan:
- Reset then imemREN=1, imemaddr=0x00000040 -> ihit=0; next cycle iREN=1, iaddr=0x40. Drive iwait=0 with iload=0xDEADBEEF after 3 cycles -> iREN=0 the following cycle, then ihit=1 and imemload=0xDEADBEEF.
- Conflict: fill 0x40, then request 0x80 (same idx 0 with SETS=16) -> miss and refill. Re-request 0x40 -> miss again, refetched with iaddr=0x40.
- Address change mid-miss: miss on 0x10, switch imemaddr to 0x20 while iwait=1 -> iaddr stays 0x10 until done; frame idx 4 filled; 0x20 then misses.
- RST=1 during FETCH with iwait=1 -> next cycle iREN=0; a later request to the same address misses, with no stale hit.
- Misaligned request 0x00000047 after filling 0x44 -> hit with the 0x44 data; iaddr is never unaligned.
- ICACHE_PREFETCH_EN:
  - Miss on 0x100 -> after fill, iREN stays 1 with iaddr=0x104; a 0x104 request afterwards hits with 0 extra latency.
  - A hit on filled 0x100 during the prefetch returns ihit=1.
  - Miss on 0xFFFFFFFC -> no prefetch (IDLE directly).
